// File: rtl/packet_assembler.sv
// Transmit-side packet assembler: serialises three captured headers followed by a
// byte-shifted payload stream onto the raw wire bus, with a registered output stage.
module packet_assembler #(
  parameter int packet_width_bytes   = 8,
  parameter int header_a_width_bytes = 4,
  parameter int header_b_width_bytes = 6,
  parameter int header_c_width_bytes = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [8*header_a_width_bytes-1:0] header_a,
  input  logic                            header_a_valid,
  input  logic [8*header_b_width_bytes-1:0] header_b,
  input  logic                            header_b_valid,
  input  logic [8*header_c_width_bytes-1:0] header_c,
  input  logic                            header_c_valid,
  input  logic                            payload_valid,
  input  logic [8*packet_width_bytes-1:0] payload,
  input  logic [packet_width_bytes-1:0]   byte_enable,
  input  logic                            sop,
  input  logic                            eop,
  output logic                            payload_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [8*packet_width_bytes-1:0] out_data,
  output logic [packet_width_bytes-1:0]   out_byte_enable,
  output logic                            out_sop,
  output logic                            out_eop
);

  localparam int W    = packet_width_bytes;
  localparam int DW   = 8 * W;
  localparam int H    = header_a_width_bytes + header_b_width_bytes + header_c_width_bytes;
  localparam int HW   = 8 * H;
  localparam int F    = H / W;
  localparam int R    = H % W;
  localparam int CB   = (R == 0) ? 1 : R;
  localparam int CNTW = $clog2(2 * W + 1);
  localparam int FCW  = (F > 1) ? $clog2(F) : 1;

  typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;

  state_t                          state_q;
  logic                            flagA_q, flagB_q, flagC_q;
  logic [8*header_a_width_bytes-1:0] hdrA_q, hdrA_d;
  logic [8*header_b_width_bytes-1:0] hdrB_q, hdrB_d;
  logic [8*header_c_width_bytes-1:0] hdrC_q, hdrC_d;
  logic [8*CB-1:0]                 carry_q;
  logic [FCW-1:0]                  hdrCnt_q;
  logic [CNTW-1:0]                 tailBytes_q;
  logic                            sopPending_q;
  logic                            outValid_q, outSop_q, outEop_q;
  logic [W-1:0]                    outBe_q;
  logic [DW-1:0]                   outData_q;

  logic                            loadEn, accept, allHdr_d, eopFits;
  logic [HW-1:0]                   hdrAll_d, hdrAll_q;
  logic [HW+DW-1:0]                hdrPad_d, hdrShift;
  logic [DW-1:0]                   firstBeat_d, hdrBeat, bodyBeat, tailBeat;
  logic [8*CB+DW-1:0]              bodyWide, tailWide;
  logic [CNTW-1:0]                 validBytes, eopSum;
  logic [W-1:0]                    eopBe, tailBe;

  function automatic logic [W-1:0] topMask(input logic [CNTW-1:0] k);
    logic [W-1:0] m;
    m = (k >= CNTW'(W)) ? {W{1'b1}} : ~({W{1'b1}} >> k);
    return m;
  endfunction

  function automatic logic [DW-1:0] byteMask(input logic [W-1:0] be);
    logic [DW-1:0] m;
    for (int i = 0; i < W; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  assign loadEn        = !outValid_q | out_ready;
  assign payload_ready = (state_q == BODY) & loadEn;
  assign accept        = payload_valid & payload_ready;

  // Header values as they will be after this edge, so the first beat can load
  // on the same edge that captures the last outstanding header.
  assign hdrA_d   = header_a_valid ? header_a : hdrA_q;
  assign hdrB_d   = header_b_valid ? header_b : hdrB_q;
  assign hdrC_d   = header_c_valid ? header_c : hdrC_q;
  assign allHdr_d = (flagA_q | header_a_valid) & (flagB_q | header_b_valid) & (flagC_q | header_c_valid);
  assign hdrAll_d = {hdrA_d, hdrB_d, hdrC_d};
  assign hdrAll_q = {hdrA_q, hdrB_q, hdrC_q};

  assign hdrPad_d    = {hdrAll_d, {DW{1'b0}}};
  assign firstBeat_d = hdrPad_d[HW+DW-1 -: DW];
  assign hdrShift    = {hdrAll_q, {DW{1'b0}}} << (DW * int'(hdrCnt_q));
  assign hdrBeat     = hdrShift[HW+DW-1 -: DW];

  assign bodyWide = {carry_q, payload};
  assign bodyBeat = (R == 0) ? payload : bodyWide[8*CB+DW-1 -: DW];
  assign tailWide = {carry_q, {DW{1'b0}}};
  assign tailBeat = tailWide[8*CB+DW-1 -: DW];

  always_comb begin
    validBytes = '0;
    for (int i = 0; i < W; i++) validBytes = validBytes + CNTW'(byte_enable[i]);
  end

  assign eopSum  = CNTW'(R) + validBytes;
  assign eopFits = eopSum <= CNTW'(W);
  assign eopBe   = topMask(eopSum);
  assign tailBe  = topMask(tailBytes_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flagA_q      <= 1'b0;
      flagB_q      <= 1'b0;
      flagC_q      <= 1'b0;
      hdrA_q       <= '0;
      hdrB_q       <= '0;
      hdrC_q       <= '0;
      carry_q      <= '0;
      hdrCnt_q     <= '0;
      tailBytes_q  <= '0;
      sopPending_q <= 1'b0;
      outValid_q   <= 1'b0;
      outSop_q     <= 1'b0;
      outEop_q     <= 1'b0;
      outBe_q      <= '0;
      outData_q    <= '0;
    end else begin
      if (loadEn) outValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (header_a_valid) begin hdrA_q <= header_a; flagA_q <= 1'b1; end
          if (header_b_valid) begin hdrB_q <= header_b; flagB_q <= 1'b1; end
          if (header_c_valid) begin hdrC_q <= header_c; flagC_q <= 1'b1; end
          if (allHdr_d && loadEn) begin
            carry_q      <= hdrAll_d[8*CB-1:0];
            sopPending_q <= 1'b1;
            if (F > 0) begin
              outValid_q <= 1'b1;
              outSop_q   <= 1'b1;
              outEop_q   <= 1'b0;
              outBe_q    <= '1;
              outData_q  <= firstBeat_d;
              hdrCnt_q   <= FCW'(1);
              state_q    <= (F == 1) ? BODY : HDR;
            end else begin
              state_q <= BODY;
            end
          end
        end
        HDR: begin
          if (loadEn) begin
            outValid_q <= 1'b1;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b0;
            outBe_q    <= '1;
            outData_q  <= hdrBeat;
            hdrCnt_q   <= hdrCnt_q + FCW'(1);
            if (hdrCnt_q == FCW'(F - 1)) begin
              carry_q      <= hdrAll_q[8*CB-1:0];
              sopPending_q <= 1'b1;
              state_q      <= BODY;
            end
          end
        end
        BODY: begin
          // Until a sop beat arrives, accepted beats are swallowed without output.
          if (accept && !(sopPending_q && !sop)) begin
            sopPending_q <= 1'b0;
            outValid_q   <= 1'b1;
            outSop_q     <= (F == 0) && sopPending_q;
            carry_q      <= payload[8*CB-1:0];
            if (eop && eopFits) begin
              outEop_q  <= 1'b1;
              outBe_q   <= eopBe;
              outData_q <= bodyBeat & byteMask(eopBe);
              flagA_q   <= 1'b0;
              flagB_q   <= 1'b0;
              flagC_q   <= 1'b0;
              state_q   <= IDLE;
            end else begin
              outEop_q  <= 1'b0;
              outBe_q   <= '1;
              outData_q <= bodyBeat;
              if (eop) begin
                tailBytes_q <= eopSum - CNTW'(W);
                state_q     <= TAIL;
              end
            end
          end
        end
        TAIL: begin
          if (loadEn) begin
            outValid_q <= 1'b1;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b1;
            outBe_q    <= tailBe;
            outData_q  <= tailBeat & byteMask(tailBe);
            flagA_q    <= 1'b0;
            flagB_q    <= 1'b0;
            flagC_q    <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid       = outValid_q;
  assign out_sop         = outSop_q;
  assign out_eop         = outEop_q;
  assign out_byte_enable = outBe_q;
  assign out_data        = outData_q;

endmodule

// File: doc/packet_assembler.md
Name: packet_assembler

Overview:
- Inverse of payload_aligner.
- Takes three parsed headers (header_a, header_b, header_c) plus an aligned payload stream (sop/eop/byte_enable). Emits the raw wire-format packet stream: headers first, then payload, byte-shifted so there are no gaps.
- Sits on the transmit path. Drives the same raw packet bus that payload_aligner consumes, so the pair can run as a loopback.

Parameters:
- packet_width_bytes, 8, bus width W in bytes; packet_width_bits = 8*W.
- header_a_width_bytes, 4, size of header_a in bytes.
- header_b_width_bytes, 6, size of header_b in bytes.
- header_c_width_bytes, 2, size of header_c in bytes.
- Derived: H = sum of the header widths (12); F = H div W (1); R = H mod W (4).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- header_a  in  8*header_a_width_bytes  header A value
- header_a_valid  in  1  header A valid, single-cycle qualifier
- header_b  in  8*header_b_width_bytes  header B value
- header_b_valid  in  1  header B valid
- header_c  in  8*header_c_width_bytes  header C value
- header_c_valid  in  1  header C valid
- payload_valid  in  1  input payload beat valid
- payload  in  8*W  input payload, first byte in MSBs
- byte_enable  in  W  input byte valids; bit i covers bits [(i+1)*8-1 -: 8]
- sop  in  1  first payload beat
- eop  in  1  last payload beat
- payload_ready  out  1  input beat accepted when payload_valid & payload_ready
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  8*W  wire data, first byte in MSBs
- out_byte_enable  out  W  output byte valids
- out_sop  out  1  first wire beat
- out_eop  out  1  last wire beat

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; header-captured flags cleared; carry register cleared.
  - out_valid, out_sop, out_eop = 0; out_byte_enable = 0; out_data = 0; payload_ready = 0.
  - Reset mid-packet abandons the packet; no eop is emitted.
- Header capture (IDLE only):
  - Each header_x is latched on the edge where header_x_valid = 1, and its flag is set. Headers may arrive on different cycles.
  - header_x_valid outside IDLE is ignored.
- Wire byte order: header_a MS byte first, then the rest of header_a, then header_b and header_c (each MS byte first), then payload bytes MSB-first.
- Output register: out_* is a registered stage.
  - A new beat loads when !out_valid | out_ready.
  - out_* is held stable while out_valid & !out_ready.
- payload_ready = (state == BODY) & (!out_valid | out_ready). It is low in IDLE, HDR and TAIL.
- State IDLE:
  - When all three flags are set, go to HDR.
  - If F = 0, go straight to BODY.
- State HDR: emits F full header beats.
  - First beat: out_sop = 1, out_byte_enable all ones.
  - After the F-th beat loads, go to BODY.
  - The first output beat is valid the cycle after the last header flag is set (out_ready high).
- State BODY:
  - First beat accepted after entering BODY must have sop = 1. Beats without sop at this point are accepted and dropped.
  - sop on later beats is ignored and the beat is treated as data.
  - Each accepted beat emits one output beat = {carry (R bytes), top W-R bytes of payload}.
  - The low R bytes of payload go to carry. Carry is initialised with the last R header bytes on entering BODY.
  - If R = 0, the block is a pass-through and the carry is unused.
- eop beat with n valid bytes (byte_enable contiguous from the MSB, n >= 1):
  - If R + n <= W: that output beat has out_eop = 1 and out_byte_enable = top R+n bits set. Then clear flags and go to IDLE.
  - Else: emit a full beat, then go to TAIL.
- State TAIL: emits one beat of the remaining R+n-W bytes from carry, with out_eop = 1 and matching out_byte_enable. Then clear flags and go to IDLE.
- sop & eop on the same beat is legal.
- Bytes outside out_byte_enable are don't-care in behaviour. The RTL drives them to 0.
- Throughput: one input beat per cycle in BODY with out_ready high. Total output beats = ceil((H + payload bytes) / W).

Test Plan:
- Golden packet:
  - Stimulus: header_a = A0A1A2A3, header_b = B0..B5, header_c = C0C1; payload beat 00..07 with sop; beat 08..0F with eop, byte_enable = FF.
  - Required response: out beats A0A1A2A3B0B1B2B3 (sop, FF); B4B5C0C1_00010203; 0405060708090A0B; 0C0D0E0F_00000000 (eop, F0).
- Short eop:
  - Stimulus: same headers; single beat sop & eop, byte_enable = E0, data 00..02.
  - Required response: beat 1 = B4B5C0C1_000102_00, byte_enable = FE, eop; no TAIL beat.
- Staggered headers:
  - Stimulus: header_c valid at cycle 0, header_a at 3, header_b at 7.
  - Required response: first out_sop at cycle 8; payload_ready stays 0 until BODY.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 through the golden packet.
  - Required response: out_* stable while stalled; payload_ready = 0 during stalls; byte stream identical to the golden packet.
- Reset mid-packet:
  - Stimulus: rst_n low for one edge after 1 output beat.
  - Required response: out_valid = 0 next cycle; flags clear; the next full packet assembles correctly.
- Loopback:
  - Stimulus: 200 random packets (1..64 payload bytes) through packet_assembler into payload_aligner.
  - Required response: headers and payload match at the payload_aligner_intf.read() task.
